// File: rtl/vga_pkg.sv
// Shared types and defaults for the VGA video-RAM arbiter slice.
package vga_pkg;

  localparam int unsigned VGA_AW = 19;
  localparam int unsigned VGA_DW = 8;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_DISP = 2'd1,
    OWN_CPU  = 2'd2
  } own_e;

endpackage

// File: rtl/vga_rdpipe.sv
// Read-return pipeline: carries an owner tag per memory access and steers
// the returning mem_rdata into the display or CPU data register.
module vga_rdpipe
  import vga_pkg::*;
#(
  parameter int unsigned DW     = VGA_DW,
  parameter int unsigned RD_LAT = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  own_e          tag_in,
  input  logic [DW-1:0] mem_rdata,
  output logic          disp_valid,
  output logic [DW-1:0] disp_rdata,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata
);

  own_e          tag_q [RD_LAT];
  own_e          tag_d [RD_LAT];
  own_e          head;
  logic          disp_valid_q, disp_valid_d;
  logic          cpu_rvalid_q, cpu_rvalid_d;
  logic [DW-1:0] disp_rdata_q, disp_rdata_d;
  logic [DW-1:0] cpu_rdata_q,  cpu_rdata_d;

  // tag_in is the tag of the access on the memory bus this cycle; the head
  // stage therefore lines up with mem_rdata exactly RD_LAT cycles later.
  always_comb begin
    tag_d[0] = tag_in;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
    head         = tag_q[RD_LAT-1];
    disp_valid_d = (head == OWN_DISP);
    cpu_rvalid_d = (head == OWN_CPU);
    disp_rdata_d = disp_valid_d ? mem_rdata : disp_rdata_q;
    cpu_rdata_d  = cpu_rvalid_d ? mem_rdata : cpu_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= OWN_NONE;
      end
      disp_valid_q <= 1'b0;
      cpu_rvalid_q <= 1'b0;
      disp_rdata_q <= '0;
      cpu_rdata_q  <= '0;
    end else begin
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        tag_q[i] <= tag_d[i];
      end
      disp_valid_q <= disp_valid_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      disp_rdata_q <= disp_rdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
    end
  end

  assign disp_valid = disp_valid_q;
  assign disp_rdata = disp_rdata_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;

endmodule

// File: rtl/vga_vram_arbiter.sv
// Single-port video RAM arbiter: display fetch has absolute priority, the
// CPU port takes the leftover slots via req/ack, read data is routed back.
module vga_vram_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned AW         = VGA_AW,
  parameter int unsigned DW         = VGA_DW,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned STARVE_LIM = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_valid,
  output logic [DW-1:0] disp_rdata,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  output logic          cpu_starve,
  output logic          mem_ce,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned WW = $clog2(STARVE_LIM) + 1;
  localparam logic [WW-1:0] LIM = WW'(STARVE_LIM);

  logic          grant_disp, grant_cpu;
  logic          mem_ce_q, mem_ce_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          cpu_ack_q, cpu_ack_d;
  own_e          own_q, own_d;
  logic [WW-1:0] cpu_wait_q, cpu_wait_d;
  logic          cpu_starve_q, cpu_starve_d;

  // A request seen while cpu_ack is high is the one already being served.
  always_comb begin
    grant_disp  = disp_req;
    grant_cpu   = !disp_req && cpu_req && !cpu_ack_q;
    mem_ce_d    = grant_disp || grant_cpu;
    mem_we_d    = grant_cpu && cpu_we;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    own_d       = OWN_NONE;
    if (grant_disp) begin
      mem_addr_d = disp_addr;
      own_d      = OWN_DISP;
    end else if (grant_cpu) begin
      mem_addr_d  = cpu_addr;
      mem_wdata_d = cpu_wdata;
      own_d       = cpu_we ? OWN_NONE : OWN_CPU;
    end
    cpu_ack_d = grant_cpu;

    if (!cpu_req || cpu_ack_q) begin
      cpu_wait_d = '0;
    end else if (cpu_wait_q != '1) begin
      cpu_wait_d = cpu_wait_q + 1'b1;
    end else begin
      cpu_wait_d = cpu_wait_q;
    end
    cpu_starve_d = (cpu_wait_d >= LIM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_ce_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_ack_q    <= 1'b0;
      own_q        <= OWN_NONE;
      cpu_wait_q   <= '0;
      cpu_starve_q <= 1'b0;
    end else begin
      mem_ce_q     <= mem_ce_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_ack_q    <= cpu_ack_d;
      own_q        <= own_d;
      cpu_wait_q   <= cpu_wait_d;
      cpu_starve_q <= cpu_starve_d;
    end
  end

  vga_rdpipe #(
    .DW     (DW),
    .RD_LAT (RD_LAT)
  ) u_rdpipe (
    .clk        (clk),
    .reset      (reset),
    .tag_in     (own_q),
    .mem_rdata  (mem_rdata),
    .disp_valid (disp_valid),
    .disp_rdata (disp_rdata),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata)
  );

  assign mem_ce     = mem_ce_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_ack    = cpu_ack_q;
  assign cpu_starve = cpu_starve_q;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Scoreboard bench for vga_vram_arbiter: directed scenarios push expected
// memory accesses, acks and read returns; a negedge monitor consumes them.
module tb_vga_vram_arbiter;

  localparam int unsigned AW = 19;
  localparam int unsigned DW = 8;
  localparam int unsigned RD_LAT = 2;
  localparam int unsigned MEM_WORDS = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic          disp_req;
  logic [AW-1:0] disp_addr;
  logic          disp_valid;
  logic [DW-1:0] disp_rdata;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_ack;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_starve;
  logic          mem_ce;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  vga_vram_arbiter #(
    .AW         (AW),
    .DW         (DW),
    .RD_LAT     (RD_LAT),
    .STARVE_LIM (64)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .disp_req   (disp_req),
    .disp_addr  (disp_addr),
    .disp_valid (disp_valid),
    .disp_rdata (disp_rdata),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ack    (cpu_ack),
    .cpu_rvalid (cpu_rvalid),
    .cpu_rdata  (cpu_rdata),
    .cpu_starve (cpu_starve),
    .mem_ce     (mem_ce),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model: unwritten words read as addr[7:0] ^ 8'h5A.
  logic [DW-1:0] mem [MEM_WORDS];
  logic [DW-1:0] rd_pipe [RD_LAT];

  initial begin
    for (int i = 0; i < int'(MEM_WORDS); i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[19'h00010] = 8'hA5;
    for (int i = 0; i < int'(RD_LAT); i++) rd_pipe[i] = '0;
  end

  always @(posedge clk) begin
    rd_pipe[0] <= (mem_ce && !mem_we) ? mem[mem_addr] : 8'h00;
    for (int k = 1; k < int'(RD_LAT); k++) rd_pipe[k] <= rd_pipe[k-1];
    if (mem_ce && mem_we) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata = rd_pipe[RD_LAT-1];

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  bit mon_en = 1'b0;

  task automatic check(input string name, input bit ok,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (ok) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    int unsigned   cyc;
    logic [DW-1:0] data;
  } rd_exp_t;

  typedef struct {
    int unsigned   cyc;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } mem_exp_t;

  rd_exp_t     disp_q[$];
  rd_exp_t     cpu_q[$];
  mem_exp_t    mem_q[$];
  int unsigned ack_q[$];

  function automatic void exp_mem(int unsigned c, logic we, logic [AW-1:0] a, logic [DW-1:0] d);
    mem_exp_t e;
    e.cyc = c; e.we = we; e.addr = a; e.wdata = d;
    mem_q.push_back(e);
  endfunction

  function automatic void exp_disp(int unsigned c, logic [DW-1:0] d);
    rd_exp_t e;
    e.cyc = c; e.data = d;
    disp_q.push_back(e);
  endfunction

  function automatic void exp_cpu(int unsigned c, logic [DW-1:0] d);
    rd_exp_t e;
    e.cyc = c; e.data = d;
    cpu_q.push_back(e);
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (mon_en) begin
      rd_exp_t  r;
      mem_exp_t m;
      int unsigned a;
      if (disp_valid && cpu_rvalid) check("valid_exclusive", 1'b0, 32'd1, 32'd0);
      if (disp_valid) begin
        if (disp_q.size() == 0) check("disp_valid_unexpected", 1'b0, 32'd1, 32'd0);
        else begin
          r = disp_q.pop_front();
          check("disp_valid_cycle", cyc == r.cyc, cyc, r.cyc);
          check("disp_rdata", disp_rdata == r.data, 32'(disp_rdata), 32'(r.data));
        end
      end else if (disp_q.size() != 0 && disp_q[0].cyc < cyc) begin
        r = disp_q.pop_front();
        check("disp_valid_missing", 1'b0, 32'd0, r.cyc);
      end
      if (cpu_rvalid) begin
        if (cpu_q.size() == 0) check("cpu_rvalid_unexpected", 1'b0, 32'd1, 32'd0);
        else begin
          r = cpu_q.pop_front();
          check("cpu_rvalid_cycle", cyc == r.cyc, cyc, r.cyc);
          check("cpu_rdata", cpu_rdata == r.data, 32'(cpu_rdata), 32'(r.data));
        end
      end else if (cpu_q.size() != 0 && cpu_q[0].cyc < cyc) begin
        r = cpu_q.pop_front();
        check("cpu_rvalid_missing", 1'b0, 32'd0, r.cyc);
      end
      if (mem_ce) begin
        if (mem_q.size() == 0) check("mem_ce_unexpected", 1'b0, 32'(mem_addr), 32'd0);
        else begin
          m = mem_q.pop_front();
          check("mem_ce_cycle", cyc == m.cyc, cyc, m.cyc);
          check("mem_we", mem_we == m.we, 32'(mem_we), 32'(m.we));
          check("mem_addr", mem_addr == m.addr, 32'(mem_addr), 32'(m.addr));
          if (m.we) check("mem_wdata", mem_wdata == m.wdata, 32'(mem_wdata), 32'(m.wdata));
        end
      end else begin
        if (mem_we) check("mem_we_idle", 1'b0, 32'd1, 32'd0);
        if (mem_q.size() != 0 && mem_q[0].cyc < cyc) begin
          m = mem_q.pop_front();
          check("mem_ce_missing", 1'b0, 32'd0, m.cyc);
        end
      end
      if (cpu_ack) begin
        if (ack_q.size() == 0) check("cpu_ack_unexpected", 1'b0, 32'd1, 32'd0);
        else begin
          a = ack_q.pop_front();
          check("cpu_ack_cycle", cyc == a, cyc, a);
        end
      end else if (ack_q.size() != 0 && ack_q[0] < cyc) begin
        a = ack_q.pop_front();
        check("cpu_ack_missing", 1'b0, 32'd0, a);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    logic [63:0] v;
    v = {mem_ce, mem_we, mem_addr, mem_wdata, cpu_ack, cpu_rvalid, cpu_rdata,
         disp_valid, disp_rdata, cpu_starve};
    check(tag, v == '0, v[31:0] | 32'(v[63:32] != '0), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int unsigned c;
    reset = 1'b1; disp_req = 1'b0; disp_addr = '0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (3) tick();
    check_all_zero("reset_outputs");
    reset = 1'b0;
    mon_en = 1'b1;
    tick(); tick();

    // Single display read
    c = cyc;
    disp_req = 1'b1; disp_addr = 19'h00010;
    exp_mem(c + 1, 1'b0, 19'h00010, 8'h00);
    exp_disp(c + 4, 8'hA5);
    tick(); disp_req = 1'b0;
    repeat (6) tick();

    // CPU write then read back
    c = cyc;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 19'h7FFFF; cpu_wdata = 8'h3C;
    exp_mem(c + 1, 1'b1, 19'h7FFFF, 8'h3C);
    ack_q.push_back(c + 1);
    tick(); cpu_req = 1'b0;
    tick(); cpu_req = 1'b1; cpu_we = 1'b0; cpu_wdata = 8'h00;
    exp_mem(c + 3, 1'b0, 19'h7FFFF, 8'h00);
    ack_q.push_back(c + 3);
    exp_cpu(c + 6, 8'h3C);
    tick(); cpu_req = 1'b0;
    repeat (6) tick();

    // Simultaneous display and CPU requests
    c = cyc;
    disp_req = 1'b1; disp_addr = 19'h00010;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h7FFFF;
    exp_mem(c + 1, 1'b0, 19'h00010, 8'h00);
    exp_mem(c + 2, 1'b0, 19'h7FFFF, 8'h00);
    ack_q.push_back(c + 2);
    exp_disp(c + 4, 8'hA5);
    exp_cpu(c + 5, 8'h3C);
    tick(); disp_req = 1'b0;
    tick(); cpu_req = 1'b0;
    repeat (6) tick();

    // 70-cycle display burst starving a held CPU read
    c = cyc;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h00020;
    for (int unsigned i = 0; i < 70; i++) begin
      disp_req = 1'b1; disp_addr = 19'h00100 + 19'(i);
      exp_mem(c + 1 + i, 1'b0, 19'h00100 + 19'(i), 8'h00);
      exp_disp(c + 4 + i, 8'(i) ^ 8'h5A);
      if (i == 63) check("starve_before_lim", cpu_starve == 1'b0, 32'(cpu_starve), 32'd0);
      if (i == 64) check("starve_at_lim", cpu_starve == 1'b1, 32'(cpu_starve), 32'd1);
      tick();
    end
    disp_req = 1'b0;
    exp_mem(c + 71, 1'b0, 19'h00020, 8'h00);
    ack_q.push_back(c + 71);
    exp_cpu(c + 74, 8'h7A);
    tick();
    check("starve_in_ack_cycle", cpu_starve == 1'b1, 32'(cpu_starve), 32'd1);
    cpu_req = 1'b0;
    tick();
    check("starve_cleared", cpu_starve == 1'b0, 32'(cpu_starve), 32'd0);
    repeat (6) tick();

    // Three back-to-back CPU reads with cpu_req held high
    c = cyc;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 19'h7FFFF;
    exp_mem(c + 1, 1'b0, 19'h7FFFF, 8'h00); ack_q.push_back(c + 1); exp_cpu(c + 4, 8'h3C);
    exp_mem(c + 3, 1'b0, 19'h00010, 8'h00); ack_q.push_back(c + 3); exp_cpu(c + 6, 8'hA5);
    exp_mem(c + 5, 1'b0, 19'h00030, 8'h00); ack_q.push_back(c + 5); exp_cpu(c + 8, 8'h6A);
    tick(); cpu_addr = 19'h00010;
    tick();
    tick(); cpu_addr = 19'h00030;
    tick();
    tick(); cpu_req = 1'b0;
    repeat (6) tick();

    // Reset right after a display access is issued
    c = cyc;
    disp_req = 1'b1; disp_addr = 19'h00010;
    exp_mem(c + 1, 1'b0, 19'h00010, 8'h00);
    tick(); disp_req = 1'b0; reset = 1'b1;
    tick(); reset = 1'b0;
    check_all_zero("outputs_after_midreset");
    repeat (8) tick();

    check("scoreboard_drained",
          (disp_q.size() + cpu_q.size() + mem_q.size() + ack_q.size()) == 0,
          32'(disp_q.size() + cpu_q.size() + mem_q.size() + ack_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
